// File: rtl/proc_sequencer.sv
// proc_sequencer: control unit for the 8-bit processor datapath.
//
// There are two modes:
//  - Manual: a user button press executes the instruction on sw_i once.
//  - Run: a run button press steps through program memory from address 0
//    up to PROG_LEN-1, then returns to idle.
//
// Each instruction is decoded into register-file, ALU and display control.
//
// Ports:
//   clk_i         system clock, all state on rising edge
//   clr_ni        asynchronous active-low reset
//   sw_i          manual instruction word
//   btn_i         raw buttons: [0] user (manual execute), [1] run
//   imem_addr_o   program ROM address (always the PC)
//   imem_data_i   ROM read data, valid one cycle after imem_addr_o
//   rf_rd_x_o     register-file read port A select (IR[5:4])
//   rf_rd_y_o     register-file read port B select (IR[3:2])
//   rf_wr_en_o    register write strobe, one cycle per writing instruction
//   rf_wr_addr_o  write destination (IR[5:4])
//   rf_wr_sel_o   write source: 00 imm, 01 R[Y], 10 ALU result
//   imm_o         immediate (IR[3:0]), zero-extended by the datapath
//   alu_funct_o   00 add, 01 sub, 10 and, 11 not (IR[1:0])
//   disp_en_o     latch R[X][3:0] into the LED register, one-cycle strobe
//   busy_o        high whenever the sequencer is not idle
module proc_sequencer #(
    parameter int unsigned PC_WIDTH    = 4,
    parameter int unsigned PROG_LEN    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                clr_ni,
    input  logic [7:0]          sw_i,
    input  logic [1:0]          btn_i,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic [7:0]          imem_data_i,
    output logic [1:0]          rf_rd_x_o,
    output logic [1:0]          rf_rd_y_o,
    output logic                rf_wr_en_o,
    output logic [1:0]          rf_wr_addr_o,
    output logic [1:0]          rf_wr_sel_o,
    output logic [3:0]          imm_o,
    output logic [1:0]          alu_funct_o,
    output logic                disp_en_o,
    output logic                busy_o
);

    localparam logic [PC_WIDTH-1:0] LastPc = PC_WIDTH'(PROG_LEN - 1);
    localparam logic [1:0]          OpStore = 2'b01;
    localparam logic [1:0]          OpMove  = 2'b10;
    localparam logic [1:0]          OpAlu   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StManExec,
        StFetch,
        StLoadIr,
        StExec
    } state_e;

    // ------------------------------------------------------------------
    // Button synchronisers and rising-edge detectors
    // ------------------------------------------------------------------
    logic [1:0][SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0]      fill_q;   // marks when sync_q holds real samples
    logic [1:0]                  prev_q;
    logic [1:0]                  armed_q;
    logic [1:0]                  btn_lvl;
    logic [1:0]                  btn_pulse;
    logic                        sync_valid;

    always_comb begin
        sync_valid = fill_q[SYNC_STAGES-1];
        btn_lvl    = '0;
        btn_pulse  = '0;
        for (int b = 0; b < 2; b++) begin
            btn_lvl[b]   = sync_q[b][SYNC_STAGES-1];
            // Only a button first seen released after reset may produce a
            // pulse, so a press held through reset release is ignored.
            btn_pulse[b] = armed_q[b] & btn_lvl[b] & ~prev_q[b];
        end
    end

    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= '0;
            armed_q <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], btn_i[b]};
            end
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= btn_lvl;
            armed_q <= armed_q | ({2{sync_valid}} & ~btn_lvl);
        end
    end

    logic user_pulse;
    logic run_pulse;

    assign user_pulse = btn_pulse[0];
    assign run_pulse  = btn_pulse[1];

    // ------------------------------------------------------------------
    // Sequencer FSM with registered strobes
    // ------------------------------------------------------------------
    state_e              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [7:0]          ir_q;
    logic                wr_en_q;
    logic                disp_en_q;
    logic                busy_q;

    // Strobes are registered on entry to an execute state, so they are
    // computed from the word about to be loaded into IR.
    always_ff @(posedge clk_i or negedge clr_ni) begin
        if (!clr_ni) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            ir_q      <= '0;
            wr_en_q   <= 1'b0;
            disp_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wr_en_q   <= 1'b0;
            disp_en_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (run_pulse) begin
                        pc_q    <= '0;
                        state_q <= StFetch;
                        busy_q  <= 1'b1;
                    end else if (user_pulse) begin
                        ir_q      <= sw_i;
                        state_q   <= StManExec;
                        busy_q    <= 1'b1;
                        wr_en_q   <= (sw_i[7:6] != OpStore);
                        disp_en_q <= (sw_i[7:6] == OpStore);
                    end
                end
                StManExec: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                StFetch: begin
                    state_q <= StLoadIr;
                end
                StLoadIr: begin
                    ir_q      <= imem_data_i;
                    state_q   <= StExec;
                    wr_en_q   <= (imem_data_i[7:6] != OpStore);
                    disp_en_q <= (imem_data_i[7:6] == OpStore);
                end
                StExec: begin
                    if (pc_q == LastPc) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        pc_q    <= pc_q + PC_WIDTH'(1);
                        state_q <= StFetch;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Combinational decode from IR
    // ------------------------------------------------------------------
    always_comb begin
        rf_rd_x_o    = ir_q[5:4];
        rf_rd_y_o    = ir_q[3:2];
        rf_wr_addr_o = ir_q[5:4];
        imm_o        = ir_q[3:0];
        alu_funct_o  = ir_q[1:0];
        rf_wr_sel_o  = 2'b00;
        case (ir_q[7:6])
            OpMove:  rf_wr_sel_o = 2'b01;
            OpAlu:   rf_wr_sel_o = 2'b10;
            default: rf_wr_sel_o = 2'b00;
        endcase
    end

    assign imem_addr_o = pc_q;
    assign rf_wr_en_o  = wr_en_q;
    assign disp_en_o   = disp_en_q;
    assign busy_o      = busy_q;

endmodule
